// File: rtl/mc_bank_timing_tracker.sv
`timescale 1ns/1ps
// Per-bank and inter-bank DDR timing/state tracker: snoops issued commands, publishes legality masks
// (combinational from registered state) and flags illegal commands one cycle after issue.
module mc_bank_timing_tracker #(
    parameter int NUM_BANKS = 8,
    parameter int ROW_W     = 16,
    parameter int CNT_W     = 8,
    parameter int RFC_W     = 16,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic [2:0]                 cmd_type,
    input  logic [BANK_W-1:0]          bank_sel,
    input  logic [ROW_W-1:0]           row_addr,
    input  logic                       auto_pre,
    input  logic [CNT_W-1:0]           t_rcd,
    input  logic [CNT_W-1:0]           t_rp,
    input  logic [CNT_W-1:0]           t_ras_min,
    input  logic [CNT_W-1:0]           t_rc,
    input  logic [CNT_W-1:0]           t_rtp,
    input  logic [CNT_W-1:0]           t_wr,
    input  logic [CNT_W-1:0]           t_rrd,
    input  logic [CNT_W-1:0]           t_ccd,
    input  logic [CNT_W-1:0]           t_wtr,
    input  logic [CNT_W-1:0]           t_rtw,
    input  logic [CNT_W-1:0]           t_faw,
    input  logic [RFC_W-1:0]           t_rfc,
    output logic [NUM_BANKS-1:0]       act_ok,
    output logic [NUM_BANKS-1:0]       rd_ok,
    output logic [NUM_BANKS-1:0]       wr_ok,
    output logic [NUM_BANKS-1:0]       pre_ok,
    output logic                       ref_ok,
    output logic [NUM_BANKS-1:0]       bank_open,
    output logic [NUM_BANKS*ROW_W-1:0] open_row,
    output logic                       viol,
    output logic [1:0]                 viol_code
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [RFC_W-1:0] R_ONE = RFC_W'(1);
    localparam logic [CNT_W:0]   C_MAX = {1'b0, {CNT_W{1'b1}}};

    // A timer loaded with max(t,1)-1 reaches zero exactly t cycles after the loading command.
    function automatic logic [CNT_W-1:0] c_load(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - C_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] c_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - C_ONE;
    endfunction

    function automatic logic [RFC_W-1:0] r_load(input logic [RFC_W-1:0] t);
        return (t == '0) ? '0 : t - R_ONE;
    endfunction

    function automatic logic [RFC_W-1:0] r_dec(input logic [RFC_W-1:0] c);
        return (c == '0) ? '0 : c - R_ONE;
    endfunction

    // Auto-precharge folds the RD->PRE (or WR->PRE) gap and tRP into a single rp load.
    function automatic logic [CNT_W-1:0] ap_load(input logic [CNT_W-1:0] ta, input logic [CNT_W-1:0] tp);
        logic [CNT_W:0] sum;
        sum = {1'b0, (ta == '0) ? C_ONE : ta} + {1'b0, (tp == '0) ? C_ONE : tp} - {1'b0, C_ONE};
        return (sum > C_MAX) ? '1 : sum[CNT_W-1:0];
    endfunction

    logic                 is_act, is_rd, is_wr, is_pre, is_ref;
    logic [NUM_BANKS-1:0] bank_hit;
    logic [NUM_BANKS-1:0] open_q;
    logic [CNT_W-1:0]     rcd_q [NUM_BANKS];
    logic [CNT_W-1:0]     ras_q [NUM_BANKS];
    logic [CNT_W-1:0]     rc_q  [NUM_BANKS];
    logic [CNT_W-1:0]     rp_q  [NUM_BANKS];
    logic [CNT_W-1:0]     rtp_q [NUM_BANKS];
    logic [CNT_W-1:0]     wr_q  [NUM_BANKS];
    logic [ROW_W-1:0]     row_q [NUM_BANKS];
    logic [CNT_W-1:0]     rrd_q, ccd_q, wtr_q, rtw_q;
    logic [RFC_W-1:0]     rfc_q;
    logic [CNT_W-1:0]     faw_q [4];
    logic [3:0]           faw_pick;
    logic                 faw_ok;
    logic                 rfc_idle;
    logic                 sel_open, sel_act_ok, sel_rd_ok, sel_wr_ok, sel_pre_ok;
    logic [1:0]           code_nxt;

    assign is_act   = cmd_valid && (cmd_type == CMD_ACT);
    assign is_rd    = cmd_valid && (cmd_type == CMD_RD);
    assign is_wr    = cmd_valid && (cmd_type == CMD_WR);
    assign is_pre   = cmd_valid && (cmd_type == CMD_PRE);
    assign is_ref   = cmd_valid && (cmd_type == CMD_REF);
    assign rfc_idle = (rfc_q == '0);
    assign bank_open = open_q;

    always_comb begin
        bank_hit = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            bank_hit[b] = (bank_sel == BANK_W'(b));
    end

    // The next ACT claims the lowest free tFAW slot.
    always_comb begin
        faw_pick = '0;
        faw_ok   = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if ((faw_q[s] == '0) && !faw_ok) begin
                faw_pick[s] = 1'b1;
                faw_ok      = 1'b1;
            end
        end
    end

    always_comb begin
        act_ok = '0;
        rd_ok  = '0;
        wr_ok  = '0;
        pre_ok = '0;
        ref_ok = rfc_idle && (open_q == '0);
        for (int b = 0; b < NUM_BANKS; b++) begin
            act_ok[b] = !open_q[b] && (rc_q[b] == '0) && (rp_q[b] == '0) &&
                        (rrd_q == '0) && faw_ok && rfc_idle;
            rd_ok[b]  = open_q[b] && (rcd_q[b] == '0) && (ccd_q == '0) && (wtr_q == '0) && rfc_idle;
            wr_ok[b]  = open_q[b] && (rcd_q[b] == '0) && (ccd_q == '0) && (rtw_q == '0) && rfc_idle;
            pre_ok[b] = rfc_idle && (!open_q[b] ||
                        ((ras_q[b] == '0) && (rtp_q[b] == '0) && (wr_q[b] == '0)));
            if (rp_q[b] != '0)
                ref_ok = 1'b0;
        end
    end

    always_comb begin
        open_row = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            open_row[b*ROW_W +: ROW_W] = row_q[b];
    end

    assign sel_open   = |(open_q & bank_hit);
    assign sel_act_ok = |(act_ok & bank_hit);
    assign sel_rd_ok  = |(rd_ok & bank_hit);
    assign sel_wr_ok  = |(wr_ok & bank_hit);
    assign sel_pre_ok = |(pre_ok & bank_hit);

    always_comb begin
        code_nxt = 2'd0;
        if (cmd_valid) begin
            case (cmd_type)
                CMD_NOP: code_nxt = 2'd0;
                CMD_ACT: code_nxt = sel_open ? 2'd2 : (sel_act_ok ? 2'd0 : 2'd1);
                CMD_RD:  code_nxt = !sel_open ? 2'd2 : (sel_rd_ok ? 2'd0 : 2'd1);
                CMD_WR:  code_nxt = !sel_open ? 2'd2 : (sel_wr_ok ? 2'd0 : 2'd1);
                CMD_PRE: code_nxt = sel_pre_ok ? 2'd0 : 2'd1;
                CMD_REF: code_nxt = (open_q != '0) ? 2'd2 : (ref_ok ? 2'd0 : 2'd1);
                default: code_nxt = 2'd3;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q    <= '0;
            rrd_q     <= '0;
            ccd_q     <= '0;
            wtr_q     <= '0;
            rtw_q     <= '0;
            rfc_q     <= '0;
            viol      <= 1'b0;
            viol_code <= 2'd0;
            for (int s = 0; s < 4; s++)
                faw_q[s] <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rcd_q[b] <= '0;
                ras_q[b] <= '0;
                rc_q[b]  <= '0;
                rp_q[b]  <= '0;
                rtp_q[b] <= '0;
                wr_q[b]  <= '0;
                row_q[b] <= '0;
            end
        end else begin
            viol      <= (code_nxt != 2'd0);
            viol_code <= code_nxt;
            rrd_q     <= is_act ? c_load(t_rrd) : c_dec(rrd_q);
            ccd_q     <= (is_rd || is_wr) ? c_load(t_ccd) : c_dec(ccd_q);
            wtr_q     <= is_wr ? c_load(t_wtr) : c_dec(wtr_q);
            rtw_q     <= is_rd ? c_load(t_rtw) : c_dec(rtw_q);
            rfc_q     <= is_ref ? r_load(t_rfc) : r_dec(rfc_q);
            for (int s = 0; s < 4; s++)
                faw_q[s] <= (is_act && faw_pick[s]) ? c_load(t_faw) : c_dec(faw_q[s]);
            for (int b = 0; b < NUM_BANKS; b++) begin
                rcd_q[b] <= (is_act && bank_hit[b]) ? c_load(t_rcd)     : c_dec(rcd_q[b]);
                ras_q[b] <= (is_act && bank_hit[b]) ? c_load(t_ras_min) : c_dec(ras_q[b]);
                rc_q[b]  <= (is_act && bank_hit[b]) ? c_load(t_rc)      : c_dec(rc_q[b]);
                rtp_q[b] <= (is_rd && bank_hit[b])  ? c_load(t_rtp)     : c_dec(rtp_q[b]);
                wr_q[b]  <= (is_wr && bank_hit[b])  ? c_load(t_wr)      : c_dec(wr_q[b]);
                // PRE to an already-closed bank is a no-op for tRP.
                if (is_pre && bank_hit[b] && open_q[b])
                    rp_q[b] <= c_load(t_rp);
                else if (is_rd && bank_hit[b] && auto_pre)
                    rp_q[b] <= ap_load(t_rtp, t_rp);
                else if (is_wr && bank_hit[b] && auto_pre)
                    rp_q[b] <= ap_load(t_wr, t_rp);
                else
                    rp_q[b] <= c_dec(rp_q[b]);
                if (is_act && bank_hit[b])
                    open_q[b] <= 1'b1;
                else if (bank_hit[b] && (is_pre || ((is_rd || is_wr) && auto_pre)))
                    open_q[b] <= 1'b0;
                if (is_act && bank_hit[b])
                    row_q[b] <= row_addr;
            end
        end
    end

endmodule

// File: tb/tb_mc_bank_timing_tracker.sv
`timescale 1ns/1ps
// Directed-vector bench for mc_bank_timing_tracker; cycle k drives the command sampled at edge k
// and checks outputs at the falling edge of that cycle.
module tb_mc_bank_timing_tracker;

    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] ACT = 3'd1;
    localparam logic [2:0] RD  = 3'd2;
    localparam logic [2:0] WR  = 3'd3;
    localparam logic [2:0] PRE = 3'd4;
    localparam logic [2:0] REF = 3'd5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid, auto_pre;
    logic [2:0]   cmd_type, bank_sel;
    logic [15:0]  row_addr;
    logic [7:0]   t_rcd, t_rp, t_ras_min, t_rc, t_rtp, t_wr, t_rrd, t_ccd, t_wtr, t_rtw, t_faw;
    logic [15:0]  t_rfc;
    logic [7:0]   act_ok, rd_ok, wr_ok, pre_ok, bank_open;
    logic         ref_ok, viol;
    logic [127:0] open_row;
    logic [1:0]   viol_code;

    int n_checks = 0;
    int n_errors = 0;

    mc_bank_timing_tracker dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .bank_sel(bank_sel),
        .row_addr(row_addr), .auto_pre(auto_pre),
        .t_rcd(t_rcd), .t_rp(t_rp), .t_ras_min(t_ras_min), .t_rc(t_rc), .t_rtp(t_rtp), .t_wr(t_wr),
        .t_rrd(t_rrd), .t_ccd(t_ccd), .t_wtr(t_wtr), .t_rtw(t_rtw), .t_faw(t_faw), .t_rfc(t_rfc),
        .act_ok(act_ok), .rd_ok(rd_ok), .wr_ok(wr_ok), .pre_ok(pre_ok), .ref_ok(ref_ok),
        .bank_open(bank_open), .open_row(open_row), .viol(viol), .viol_code(viol_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] ty, input logic [2:0] bk, input logic [15:0] row, input logic ap);
        cmd_valid = 1'b1;
        cmd_type  = ty;
        bank_sel  = bk;
        row_addr  = row;
        auto_pre  = ap;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        cmd_type  = NOP;
        bank_sel  = 3'd0;
        row_addr  = 16'd0;
        auto_pre  = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_defaults();
        t_rcd = 8'd1; t_rp = 8'd1; t_ras_min = 8'd1; t_rc = 8'd1; t_rtp = 8'd1; t_wr = 8'd1;
        t_rrd = 8'd1; t_ccd = 8'd1; t_wtr = 8'd1; t_rtw = 8'd1; t_faw = 8'd1; t_rfc = 16'd1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        set_defaults();
        do_reset();

        // Reset state
        check("rst_act_ok", 32'(act_ok), 32'hFF);
        check("rst_rd_ok", 32'(rd_ok), 32'h0);
        check("rst_wr_ok", 32'(wr_ok), 32'h0);
        check("rst_pre_ok", 32'(pre_ok), 32'hFF);
        check("rst_ref_ok", 32'(ref_ok), 32'h1);
        check("rst_open", 32'(bank_open), 32'h0);
        check("rst_viol", 32'({viol, viol_code}), 32'h0);
        check("rst_row", open_row[31:0], 32'h0);

        // tRCD = 4 with an early RD
        t_rcd = 8'd4;
        for (int c = 0; c <= 4; c++) begin
            idle();
            if (c >= 1 && c <= 3) check("rcd_rd_ok_low", 32'(rd_ok[2]), 32'h0);
            if (c == 1) begin
                check("rcd_open", 32'(bank_open), 32'h04);
                check("rcd_row", 32'(open_row[2*16 +: 16]), 32'h1234);
            end
            if (c == 3) check("rcd_viol", 32'({viol, viol_code}), 32'h5);
            if (c == 4) begin
                check("rcd_rd_ok_high", 32'(rd_ok[2]), 32'h1);
                check("rcd_viol_pulse", 32'(viol), 32'h0);
            end
            if (c == 0) issue(ACT, 3'd2, 16'h1234, 1'b0);
            if (c == 2) issue(RD, 3'd2, 16'h0, 1'b0);
            tick();
        end

        // tRRD = 2, tFAW = 10
        set_defaults();
        do_reset();
        t_rrd = 8'd2;
        t_faw = 8'd10;
        for (int c = 0; c <= 10; c++) begin
            idle();
            if (c == 1) check("rrd_block", 32'(act_ok[1]), 32'h0);
            if (c >= 7) check("faw_act_ok4", 32'(act_ok[4]), 32'(c == 10));
            if (c <= 6 && (c % 2) == 0) issue(ACT, 3'(c / 2), 16'(c), 1'b0);
            tick();
        end

        // tRAS = 6, tRP = 3
        set_defaults();
        do_reset();
        t_ras_min = 8'd6;
        t_rp = 8'd3;
        for (int c = 0; c <= 9; c++) begin
            idle();
            if (c == 5) check("ras_pre_ok_low", 32'(pre_ok[1]), 32'h0);
            if (c == 6) check("ras_pre_ok_high", 32'(pre_ok[1]), 32'h1);
            if (c == 7) check("ras_closed", 32'({bank_open[1], viol}), 32'h0);
            if (c == 8) check("rp_act_ok_low", 32'(act_ok[1]), 32'h0);
            if (c == 9) check("rp_act_ok_high", 32'(act_ok[1]), 32'h1);
            if (c == 0) issue(ACT, 3'd1, 16'hAAAA, 1'b0);
            if (c == 6) issue(PRE, 3'd1, 16'h0, 1'b0);
            tick();
        end

        // RD with auto-precharge: tRTP = 2, tRP = 3 -> ACT legal 5 cycles later
        set_defaults();
        do_reset();
        t_rtp = 8'd2;
        t_rp = 8'd3;
        for (int c = 0; c <= 15; c++) begin
            idle();
            if (c == 10) check("ap_rd_ok", 32'(rd_ok[0]), 32'h1);
            if (c == 11) check("ap_closed", 32'({bank_open[0], viol}), 32'h0);
            if (c == 14) check("ap_act_ok_low", 32'(act_ok[0]), 32'h0);
            if (c == 15) check("ap_act_ok_high", 32'(act_ok[0]), 32'h1);
            if (c == 0) issue(ACT, 3'd0, 16'hBEEF, 1'b0);
            if (c == 10) issue(RD, 3'd0, 16'h0, 1'b1);
            tick();
        end

        // Error codes
        set_defaults();
        do_reset();
        issue(WR, 3'd5, 16'h0, 1'b0);
        tick();
        check("wr_closed_code", 32'({viol, viol_code}), 32'h6);
        issue(3'd7, 3'd0, 16'h0, 1'b0);
        tick();
        check("illegal_code", 32'({viol, viol_code}), 32'h7);
        check("illegal_no_update", 32'(act_ok), 32'hFF);
        issue(ACT, 3'd3, 16'h0033, 1'b0);
        tick();
        check("act_legal", 32'({viol, viol_code}), 32'h0);
        issue(REF, 3'd0, 16'h0, 1'b0);
        tick();
        check("ref_open_code", 32'({viol, viol_code}), 32'h6);
        idle();
        tick();

        // tRFC = 20, full count
        set_defaults();
        do_reset();
        t_rfc = 16'd20;
        for (int c = 0; c <= 20; c++) begin
            idle();
            if (c >= 1 && c <= 19) begin
                check("rfc_act_ok_low", 32'(act_ok), 32'h0);
                check("rfc_pre_ref_low", 32'({pre_ok, ref_ok}), 32'h0);
            end
            if (c == 20) check("rfc_act_ok_high", 32'({act_ok, ref_ok}), 32'h1FF);
            if (c == 0) issue(REF, 3'd0, 16'h0, 1'b0);
            tick();
        end

        // tRFC = 20, reset mid-count
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            idle();
            if (c == 9) begin
                rst = 1'b0;
                check("rst_mid_act_ok", 32'(act_ok), 32'hFF);
                check("rst_mid_ok", 32'({pre_ok, ref_ok, rd_ok}), 32'h1FF00);
            end
            if (c == 8) begin
                check("rfc_pre_rst", 32'(act_ok), 32'h0);
                rst = 1'b1;
            end
            if (c == 0) issue(REF, 3'd0, 16'h0, 1'b0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
